multi_alarm_ctrl: RTL and testbench

MULTI_ALARM_CTRL -- requirements
Module: multi_alarm_ctrl

---
 rtl/multi_alarm_ctrl_if.sv | 13 +
 rtl/multi_alarm_ctrl.sv | 155 +++++++++++++++
 tb/tb_multi_alarm_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_alarm_ctrl_if.sv
// Configuration write port for multi_alarm_ctrl: one alarm channel is
// programmed per wr_en strobe.
interface multi_alarm_ctrl_if #(
    parameter int unsigned IDX_W = 2
);
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [10:0]      wr_time;
    logic             wr_enable;

    modport master (output wr_en, output wr_idx, output wr_time, output wr_enable);
    modport slave  (input  wr_en, input  wr_idx, input  wr_time, input  wr_enable);
endinterface

// File: rtl/multi_alarm_ctrl.sv
// Multi-channel alarm clock controller: per-channel arm/ring/snooze state,
// with button edges applied to the lowest-index ringing channel.
module multi_alarm_ctrl #(
    parameter int unsigned NUM_ALARMS   = 4,
    parameter int unsigned IDX_W        = 2,
    parameter int unsigned SNOOZE_MIN   = 9,
    parameter int unsigned RING_TIMEOUT = 60
) (
    input  logic                  MCLK,
    input  logic                  reset,
    input  logic                  tick_sec,
    input  logic                  minute_tick,
    input  logic [10:0]           cur_min,
    input  logic                  snooze_btn,
    input  logic                  stop_btn,
    multi_alarm_ctrl_if.slave     cfg,
    output logic                  ringing,
    output logic [IDX_W-1:0]      ring_idx,
    output logic [NUM_ALARMS-1:0] armed,
    output logic [NUM_ALARMS-1:0] snoozed,
    output logic [NUM_ALARMS-1:0] missed
);

    localparam int unsigned TIME_W  = 11;
    localparam int unsigned SNZ_W   = 6;
    localparam int unsigned RING_W  = 8;
    localparam logic [TIME_W-1:0] MAX_MIN = TIME_W'(1439);

    if ((1 << IDX_W) < NUM_ALARMS) begin : g_param_err
        $error("multi_alarm_ctrl: IDX_W too small for NUM_ALARMS");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZED = 2'd2
    } state_e;

    state_e                  state_q    [NUM_ALARMS];
    logic [TIME_W-1:0]       alm_time_q [NUM_ALARMS];
    logic [SNZ_W-1:0]        snz_cnt_q  [NUM_ALARMS];
    logic [RING_W-1:0]       ring_cnt_q [NUM_ALARMS];
    logic [NUM_ALARMS-1:0]   en_q;
    logic [NUM_ALARMS-1:0]   missed_q;
    logic                    snooze_prev_q;
    logic                    stop_prev_q;
    logic                    btn_live_q;

    logic                    snooze_edge_c;
    logic                    stop_edge_c;
    logic                    wr_ok_c;
    logic [NUM_ALARMS-1:0]   ring_mask_c;
    logic [NUM_ALARMS-1:0]   active_c;

    // btn_live_q masks the first post-reset cycle so a held button never looks like a press
    assign snooze_edge_c = btn_live_q & snooze_btn & ~snooze_prev_q;
    assign stop_edge_c   = btn_live_q & stop_btn   & ~stop_prev_q;

    assign wr_ok_c = cfg.wr_en && (32'(cfg.wr_idx) < NUM_ALARMS) && (cfg.wr_time <= MAX_MIN);

    // Status decodes of registered channel state
    always_comb begin
        ring_mask_c = '0;
        snoozed     = '0;
        for (int i = 0; i < int'(NUM_ALARMS); i++) begin
            ring_mask_c[i] = (state_q[i] == ST_RINGING);
            snoozed[i]     = (state_q[i] == ST_SNOOZED);
        end
    end

    assign ringing = |ring_mask_c;
    assign armed   = en_q;
    assign missed  = missed_q;

    // Lowest-index ringing channel owns the buttons
    always_comb begin
        ring_idx = '0;
        for (int i = int'(NUM_ALARMS) - 1; i >= 0; i--) begin
            if (ring_mask_c[i]) ring_idx = IDX_W'(i);
        end
    end

    always_comb begin
        active_c = '0;
        for (int i = 0; i < int'(NUM_ALARMS); i++) begin
            active_c[i] = ring_mask_c[i] && (ring_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            snooze_prev_q <= 1'b0;
            stop_prev_q   <= 1'b0;
            btn_live_q    <= 1'b0;
            en_q          <= '0;
            missed_q      <= '0;
            for (int i = 0; i < int'(NUM_ALARMS); i++) begin
                state_q[i]    <= ST_IDLE;
                alm_time_q[i] <= '0;
                snz_cnt_q[i]  <= '0;
                ring_cnt_q[i] <= '0;
            end
        end else begin
            snooze_prev_q <= snooze_btn;
            stop_prev_q   <= stop_btn;
            btn_live_q    <= 1'b1;
            for (int i = 0; i < int'(NUM_ALARMS); i++) begin
                // A valid write overrides any match or button action on the same cycle
                if (wr_ok_c && (cfg.wr_idx == IDX_W'(i))) begin
                    alm_time_q[i] <= cfg.wr_time;
                    en_q[i]       <= cfg.wr_enable;
                    state_q[i]    <= ST_IDLE;
                    missed_q[i]   <= 1'b0;
                    snz_cnt_q[i]  <= '0;
                    ring_cnt_q[i] <= '0;
                end else begin
                    case (state_q[i])
                        ST_IDLE: begin
                            if (minute_tick && en_q[i] && (alm_time_q[i] == cur_min)) begin
                                state_q[i]    <= ST_RINGING;
                                ring_cnt_q[i] <= '0;
                            end
                        end
                        ST_RINGING: begin
                            if (active_c[i] && stop_edge_c) begin
                                state_q[i]  <= ST_IDLE;
                                missed_q[i] <= 1'b0;
                            end else if (active_c[i] && snooze_edge_c) begin
                                state_q[i]   <= ST_SNOOZED;
                                snz_cnt_q[i] <= SNZ_W'(SNOOZE_MIN);
                            end else if (tick_sec) begin
                                ring_cnt_q[i] <= ring_cnt_q[i] + RING_W'(1);
                                if ((ring_cnt_q[i] + RING_W'(1)) == RING_W'(RING_TIMEOUT)) begin
                                    state_q[i]  <= ST_IDLE;
                                    missed_q[i] <= 1'b1;
                                end
                            end
                        end
                        ST_SNOOZED: begin
                            if (minute_tick) begin
                                snz_cnt_q[i] <= snz_cnt_q[i] - SNZ_W'(1);
                                if (snz_cnt_q[i] == SNZ_W'(1)) begin
                                    state_q[i]    <= ST_RINGING;
                                    ring_cnt_q[i] <= '0;
                                end
                            end
                        end
                        default: state_q[i] <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Directed testbench for multi_alarm_ctrl: scenario tasks with hand-computed
// expectations, sampled on the falling edge.
module tb_multi_alarm_ctrl;

    logic        MCLK;
    logic        reset;
    logic        tick_sec;
    logic        minute_tick;
    logic [10:0] cur_min;
    logic        snooze_btn;
    logic        stop_btn;
    logic        ringing;
    logic [1:0]  ring_idx;
    logic [3:0]  armed;
    logic [3:0]  snoozed;
    logic [3:0]  missed;

    int checks   = 0;
    int failures = 0;

    multi_alarm_ctrl_if #(.IDX_W(2)) cfg_if ();

    multi_alarm_ctrl #(
        .NUM_ALARMS  (4),
        .IDX_W       (2),
        .SNOOZE_MIN  (9),
        .RING_TIMEOUT(60)
    ) dut (
        .MCLK       (MCLK),
        .reset      (reset),
        .tick_sec   (tick_sec),
        .minute_tick(minute_tick),
        .cur_min    (cur_min),
        .snooze_btn (snooze_btn),
        .stop_btn   (stop_btn),
        .cfg        (cfg_if),
        .ringing    (ringing),
        .ring_idx   (ring_idx),
        .armed      (armed),
        .snoozed    (snoozed),
        .missed     (missed)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Stimulus helpers: each returns on a falling edge, just after the effect is registered
    task automatic write_ch(input logic [1:0] idx, input logic [10:0] t, input logic en);
        @(negedge MCLK);
        cfg_if.wr_en     = 1'b1;
        cfg_if.wr_idx    = idx;
        cfg_if.wr_time   = t;
        cfg_if.wr_enable = en;
        @(negedge MCLK);
        cfg_if.wr_en     = 1'b0;
    endtask

    task automatic tick_min(input logic [10:0] m);
        @(negedge MCLK);
        minute_tick = 1'b1;
        cur_min     = m;
        @(negedge MCLK);
        minute_tick = 1'b0;
    endtask

    task automatic pulse_sec();
        @(negedge MCLK);
        tick_sec = 1'b1;
        @(negedge MCLK);
        tick_sec = 1'b0;
    endtask

    task automatic press(input logic snz, input logic stp);
        @(negedge MCLK);
        snooze_btn = snz;
        stop_btn   = stp;
        @(negedge MCLK);
        snooze_btn = 1'b0;
        stop_btn   = 1'b0;
        @(negedge MCLK);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge MCLK);
        checks++;
        if ({ringing, ring_idx, armed, snoozed, missed} !== 15'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected all zero", {ringing, ring_idx, armed, snoozed, missed});
        end
        reset = 1'b0;
        @(negedge MCLK);
    endtask

    task automatic test_ring();
        write_ch(2'd1, 11'd420, 1'b1);
        checks++;
        if (armed !== 4'b0010 || ringing !== 1'b0) begin
            failures++;
            $display("FAIL write_arm: armed=%b ringing=%b expected 0010/0", armed, ringing);
        end
        tick_min(11'd419);
        checks++;
        if (ringing !== 1'b0) begin
            failures++;
            $display("FAIL no_match: ringing=%b expected 0", ringing);
        end
        tick_min(11'd420);
        checks++;
        if (ringing !== 1'b1 || ring_idx !== 2'd1) begin
            failures++;
            $display("FAIL ring_ch1: ringing=%b ring_idx=%0d expected 1/1", ringing, ring_idx);
        end
    endtask

    task automatic test_snooze();
        press(1'b1, 1'b0);
        checks++;
        if (snoozed !== 4'b0010 || ringing !== 1'b0) begin
            failures++;
            $display("FAIL snooze_enter: snoozed=%b ringing=%b expected 0010/0", snoozed, ringing);
        end
        for (int k = 0; k < 8; k++) tick_min(11'(421 + k));
        checks++;
        if (snoozed !== 4'b0010 || ringing !== 1'b0) begin
            failures++;
            $display("FAIL snooze_8ticks: snoozed=%b ringing=%b expected 0010/0", snoozed, ringing);
        end
        tick_min(11'd429);
        checks++;
        if (ringing !== 1'b1 || ring_idx !== 2'd1 || snoozed !== 4'b0000) begin
            failures++;
            $display("FAIL snooze_expire: ringing=%b idx=%0d snoozed=%b expected 1/1/0000", ringing, ring_idx, snoozed);
        end
        press(1'b0, 1'b1);
        checks++;
        if (ringing !== 1'b0 || armed !== 4'b0010 || snoozed !== 4'b0000) begin
            failures++;
            $display("FAIL stop_after_snooze: ringing=%b armed=%b snoozed=%b expected 0/0010/0000", ringing, armed, snoozed);
        end
        press(1'b1, 1'b0);
        checks++;
        if (snoozed !== 4'b0000 || ringing !== 1'b0) begin
            failures++;
            $display("FAIL idle_snooze_ignored: snoozed=%b ringing=%b expected 0000/0", snoozed, ringing);
        end
    endtask

    task automatic test_multi();
        write_ch(2'd0, 11'd100, 1'b1);
        write_ch(2'd2, 11'd100, 1'b1);
        tick_min(11'd100);
        checks++;
        if (ringing !== 1'b1 || ring_idx !== 2'd0) begin
            failures++;
            $display("FAIL multi_first: ringing=%b idx=%0d expected 1/0", ringing, ring_idx);
        end
        press(1'b0, 1'b1);
        checks++;
        if (ringing !== 1'b1 || ring_idx !== 2'd2) begin
            failures++;
            $display("FAIL multi_advance: ringing=%b idx=%0d expected 1/2", ringing, ring_idx);
        end
        press(1'b0, 1'b1);
        checks++;
        if (ringing !== 1'b0 || ring_idx !== 2'd0) begin
            failures++;
            $display("FAIL multi_done: ringing=%b idx=%0d expected 0/0", ringing, ring_idx);
        end
    endtask

    task automatic test_held_button();
        write_ch(2'd0, 11'd200, 1'b1);
        write_ch(2'd1, 11'd200, 1'b1);
        tick_min(11'd200);
        @(negedge MCLK);
        stop_btn = 1'b1;
        repeat (4) @(negedge MCLK);
        stop_btn = 1'b0;
        @(negedge MCLK);
        checks++;
        if (ringing !== 1'b1 || ring_idx !== 2'd1) begin
            failures++;
            $display("FAIL held_stop_once: ringing=%b idx=%0d expected 1/1", ringing, ring_idx);
        end
        press(1'b0, 1'b1);
    endtask

    task automatic test_timeout();
        write_ch(2'd3, 11'd300, 1'b1);
        tick_min(11'd300);
        checks++;
        if (ringing !== 1'b1 || ring_idx !== 2'd3) begin
            failures++;
            $display("FAIL timeout_ring: ringing=%b idx=%0d expected 1/3", ringing, ring_idx);
        end
        for (int k = 0; k < 59; k++) pulse_sec();
        checks++;
        if (ringing !== 1'b1 || missed !== 4'b0000) begin
            failures++;
            $display("FAIL timeout_59: ringing=%b missed=%b expected 1/0000", ringing, missed);
        end
        pulse_sec();
        checks++;
        if (ringing !== 1'b0 || missed !== 4'b1000) begin
            failures++;
            $display("FAIL timeout_60: ringing=%b missed=%b expected 0/1000", ringing, missed);
        end
        write_ch(2'd3, 11'd300, 1'b1);
        checks++;
        if (missed !== 4'b0000 || armed !== 4'b1111) begin
            failures++;
            $display("FAIL missed_clear: missed=%b armed=%b expected 0000/1111", missed, armed);
        end
    endtask

    task automatic test_simul_and_bad_write();
        write_ch(2'd3, 11'd500, 1'b1);
        tick_min(11'd500);
        press(1'b1, 1'b1);
        checks++;
        if (ringing !== 1'b0 || snoozed !== 4'b0000) begin
            failures++;
            $display("FAIL stop_wins: ringing=%b snoozed=%b expected 0/0000", ringing, snoozed);
        end
        write_ch(2'd3, 11'd1500, 1'b0);
        checks++;
        if (armed !== 4'b1111 || missed !== 4'b0000) begin
            failures++;
            $display("FAIL bad_write_ignored: armed=%b missed=%b expected 1111/0000", armed, missed);
        end
        tick_min(11'd500);
        checks++;
        if (ringing !== 1'b1 || ring_idx !== 2'd3) begin
            failures++;
            $display("FAIL bad_write_time_kept: ringing=%b idx=%0d expected 1/3", ringing, ring_idx);
        end
        press(1'b0, 1'b1);
    endtask

    task automatic test_write_wins();
        @(negedge MCLK);
        cfg_if.wr_en     = 1'b1;
        cfg_if.wr_idx    = 2'd2;
        cfg_if.wr_time   = 11'd100;
        cfg_if.wr_enable = 1'b1;
        minute_tick      = 1'b1;
        cur_min          = 11'd100;
        @(negedge MCLK);
        cfg_if.wr_en     = 1'b0;
        minute_tick      = 1'b0;
        @(negedge MCLK);
        checks++;
        if (ringing !== 1'b0 || armed !== 4'b1111) begin
            failures++;
            $display("FAIL write_beats_match: ringing=%b armed=%b expected 0/1111", ringing, armed);
        end
    endtask

    task automatic test_reset_mid_snooze();
        write_ch(2'd0, 11'd700, 1'b1);
        tick_min(11'd700);
        press(1'b1, 1'b0);
        checks++;
        if (snoozed !== 4'b0001) begin
            failures++;
            $display("FAIL pre_reset_snooze: snoozed=%b expected 0001", snoozed);
        end
        @(negedge MCLK);
        reset      = 1'b1;
        snooze_btn = 1'b1;
        @(negedge MCLK);
        checks++;
        if ({ringing, ring_idx, armed, snoozed, missed} !== 15'd0) begin
            failures++;
            $display("FAIL reset_mid_snooze: got %b expected all zero", {ringing, ring_idx, armed, snoozed, missed});
        end
        reset = 1'b0;
        for (int k = 0; k < 10; k++) tick_min(11'(700 + k));
        checks++;
        if (ringing !== 1'b0 || snoozed !== 4'b0000) begin
            failures++;
            $display("FAIL post_reset_no_ring: ringing=%b snoozed=%b expected 0/0000", ringing, snoozed);
        end
        write_ch(2'd0, 11'd710, 1'b1);
        tick_min(11'd710);
        @(negedge MCLK);
        checks++;
        if (ringing !== 1'b1 || snoozed !== 4'b0000) begin
            failures++;
            $display("FAIL held_through_reset: ringing=%b snoozed=%b expected 1/0000", ringing, snoozed);
        end
        snooze_btn = 1'b0;
        press(1'b0, 1'b1);
        checks++;
        if (ringing !== 1'b0) begin
            failures++;
            $display("FAIL final_stop: ringing=%b expected 0", ringing);
        end
    endtask

    initial begin
        reset            = 1'b1;
        tick_sec         = 1'b0;
        minute_tick      = 1'b0;
        cur_min          = 11'd0;
        snooze_btn       = 1'b0;
        stop_btn         = 1'b0;
        cfg_if.wr_en     = 1'b0;
        cfg_if.wr_idx    = 2'd0;
        cfg_if.wr_time   = 11'd0;
        cfg_if.wr_enable = 1'b0;

        test_reset();
        test_ring();
        test_snooze();
        test_multi();
        test_held_button();
        test_timeout();
        test_simul_and_bad_write();
        test_write_wins();
        test_reset_mid_snooze();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
